// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues memory reads, buffers returned words with PC/epoch, presents them to decode.
// Optional FETCH_PERF_EN adds saturating stall_cycles / discard_count counters.
module fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        address_enable,
    output logic [31:0] address,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_epoch
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] discard_count
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]      fetch_pc;
    logic [31:0]      stale_pc;
    logic             epoch;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] q_pc    [QUEUE_DEPTH];
    logic [31:0] q_instr [QUEUE_DEPTH];
    logic        q_epoch [QUEUE_DEPTH];

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W:0]   occupancy;
    logic             room;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = (state == REQUEST) && data_valid && !redirect;

    // An outstanding request reserves a slot, so it counts toward occupancy.
    assign count_after_pop = count - CNT_W'(pop);
    assign occupancy       = {1'b0, count_after_pop} + (CNT_W + 1)'(state != IDLE);
    assign room            = (occupancy < DEPTH_L);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (redirect || room)
                    state_next = REQUEST;
            end
            REQUEST: begin
                if (redirect)
                    state_next = data_valid ? REQUEST : DISCARD;
                else if (data_valid)
                    state_next = room ? REQUEST : IDLE;
            end
            DISCARD: begin
                if (data_valid)
                    state_next = (redirect || room) ? REQUEST : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC & ~32'h3;
            stale_pc <= '0;
            epoch    <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            epoch    <= ~epoch;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            // Memory cannot abort, so remember the address still being served.
            if (state == REQUEST && !data_valid)
                stale_pc <= fetch_pc;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= tail + PTR_W'(1);
            end
            if (pop)
                head <= head + PTR_W'(1);
            count <= count_after_pop + CNT_W'(push);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= data;
            q_epoch[tail] <= epoch;
        end
    end

    assign address_enable  = (state != IDLE);
    assign address         = (state == REQUEST) ? fetch_pc :
                             (state == DISCARD) ? stale_pc : '0;
    assign out_instruction = out_valid ? q_instr[head] : '0;
    assign out_pc          = out_valid ? q_pc[head]    : '0;
    assign out_epoch       = out_valid ? q_epoch[head] : 1'b0;

`ifdef FETCH_PERF_EN
    logic        stall;
    logic        dropped;
    logic [15:0] discard_inc;
    logic [16:0] discard_sum;

    assign stall       = !out_valid && (state != DISCARD);
    assign dropped     = data_valid && ((state == DISCARD) || (state == REQUEST && redirect));
    assign discard_inc = (redirect ? 16'(count) : 16'd0) + 16'(dropped);
    assign discard_sum = {1'b0, discard_count} + {1'b0, discard_inc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            discard_count <= '0;
        end else begin
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            discard_count <= discard_sum[16] ? '1 : discard_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model predicts every output each cycle,
// with a request/response memory model and directed redirect, wrap and async-reset episodes.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_epoch;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] discard_count;
`endif

    fetch_queue #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .address_enable  (address_enable),
        .address         (address),
        .data            (data),
        .data_valid      (data_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_epoch       (out_epoch)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .discard_count   (discard_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of fetched words plus "request outstanding" / "its answer is stale".
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ep;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_stale_pc;
    logic        m_ep;
    bit          m_out;
    bit          m_stale;

    // Memory model
    bit          mem_pending;
    int unsigned mem_wait;
    logic [31:0] mem_addr;

    // Stimulus knobs
    int          ready_mode;
    int unsigned lat_min;
    int unsigned lat_max;
    int unsigned redir_pct;
    bit          spur_en;
    bit          force_rd;
    logic [31:0] force_pc;
    bit          rd_pend_trig;
    bit          rd_dv_trig;

    task automatic model_reset();
        mq.delete();
        m_pc        = RST_PC & ~32'h3;
        m_stale_pc  = '0;
        m_ep        = 1'b0;
        m_out       = 0;
        m_stale     = 0;
        mem_pending = 0;
        mem_wait    = 0;
        mem_addr    = '0;
    endtask

    task automatic model_step();
        int unsigned cnt;
        bit          room;
        entry_t      e;
        if (redirect) begin
            if (m_out && !m_stale && !data_valid) begin
                m_stale    = 1;
                m_stale_pc = m_pc;
            end
            m_out = 1;
            mq.delete();
            m_ep = ~m_ep;
            m_pc = redirect_pc & ~32'h3;
        end else begin
            if (mq.size() > 0 && out_ready)
                void'(mq.pop_front());
            cnt  = mq.size();
            room = (cnt + (m_out ? 1 : 0)) < DEPTH;
            if (!m_out) begin
                m_out = room;
            end else if (!m_stale) begin
                if (data_valid) begin
                    e.pc  = m_pc;
                    e.ins = data;
                    e.ep  = m_ep;
                    mq.push_back(e);
                    m_pc  = m_pc + 32'd4;
                    m_out = room;
                end
            end else if (data_valid) begin
                m_stale = 0;
                m_out   = room;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_addr;
        exp_addr = m_out ? (m_stale ? m_stale_pc : m_pc) : 32'h0;
        check_eq("address_enable", address_enable, m_out);
        check_eq("address", address, exp_addr);
        check_eq("out_valid", out_valid, mq.size() > 0);
        check_eq("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        check_eq("out_instruction", out_instruction, (mq.size() > 0) ? mq[0].ins : 32'h0);
        check_eq("out_epoch", out_epoch, (mq.size() > 0) ? mq[0].ep : 1'b0);
        if (mem_pending)
            check_eq("addr_hold", address, mem_addr);
    endtask

    task automatic drive_and_step();
        data_valid  = 1'b0;
        data        = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                data_valid  = 1'b1;
                data        = $urandom;
                mem_pending = 0;
            end else begin
                mem_wait--;
            end
        end else if (address_enable) begin
            mem_pending = 1;
            mem_addr    = address;
            mem_wait    = $urandom_range(lat_max, lat_min);
        end else if (spur_en && $urandom_range(9, 0) == 0) begin
            data_valid = 1'b1;
            data       = $urandom;
        end

        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1, 0));
        endcase

        // A redirect coinciding with the stale response is left out of the stimulus.
        if (!(m_out && m_stale && data_valid)) begin
            if (force_rd) begin
                redirect    = 1'b1;
                redirect_pc = force_pc;
                force_rd    = 0;
            end else if (rd_pend_trig && mem_pending && m_out && !m_stale) begin
                redirect     = 1'b1;
                redirect_pc  = 32'h0000_2002;
                rd_pend_trig = 0;
            end else if (rd_dv_trig && data_valid && m_out && !m_stale && mq.size() > 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                out_ready   = 1'b1;
                rd_dv_trig  = 0;
            end else if ($urandom_range(99, 0) < redir_pct) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
        end
        model_step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check_outputs();
            drive_and_step();
            @(negedge clock);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        data        = '0;
        data_valid  = 1'b0;
        out_ready   = 1'b0;
        ready_mode  = 1;
        lat_min     = 0;
        lat_max     = 0;
        redir_pct   = 0;
        spur_en     = 0;
        force_rd    = 0;
        force_pc    = '0;
        rd_pend_trig = 0;
        rd_dv_trig  = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs();
        reset = 1'b0;

        // Straight-line fetch from RESET_PC, single-cycle memory, decode always ready.
        run_cycles(14);

        // Decode stalls: queue fills, fetch idles, then drains and resumes.
        ready_mode = 0;
        run_cycles(12);
        ready_mode = 1;
        run_cycles(10);

        // Redirect while a slow request to 0x40 is in flight.
        force_rd     = 1;
        force_pc     = 32'h0000_0040;
        lat_min      = 3;
        lat_max      = 3;
        rd_pend_trig = 1;
        run_cycles(24);
        lat_min = 0;
        lat_max = 0;
        run_cycles(6);

        // Redirect in the same cycle as a response while the head is being accepted.
        ready_mode = 0;
        rd_dv_trig = 1;
        run_cycles(12);
        ready_mode = 1;
        run_cycles(6);

        // Fetch PC wraps past the top of the address space.
        force_rd = 1;
        force_pc = 32'hFFFF_FFFC;
        run_cycles(10);

        // Asynchronous reset while a request is outstanding and the queue is occupied.
        ready_mode = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_out && !m_stale && mq.size() > 0)
                found = 1;
            else
                run_cycles(1);
        end
        check_eq("rst_setup", found, 1'b1);
        check_outputs();
        #2;
        reset      = 1'b1;
        redirect   = 1'b0;
        data_valid = 1'b0;
        #1;
        check_eq("async_rst_address_enable", address_enable, 1'b0);
        check_eq("async_rst_out_valid", out_valid, 1'b0);
        model_reset();
        @(negedge clock);
        check_outputs();
        reset      = 1'b0;
        ready_mode = 1;
        run_cycles(8);

        // Random traffic: variable latency, random back-pressure, redirects, stray strobes while idle.
        ready_mode = 2;
        lat_min    = 0;
        lat_max    = 3;
        redir_pct  = 5;
        spur_en    = 1;
        run_cycles(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
